// File: rtl/pwm_cfg_update_ctrl.sv
// PWM configuration update controller: double-buffers carrier settings and commits them at mask events.
// Optional forced commit after TIMEOUT_CYCLES in PENDING is enabled by defining PWMCFG_TIMEOUT_EN.

`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

`ifndef COUNT_UP
`define COUNT_UP     2'd0
`define COUNT_DOWN   2'd1
`define COUNT_UPDOWN 2'd2
`endif

`ifndef NO_MASK
`define NO_MASK     2'd0
`define MIN_MASK    2'd1
`define MAX_MASK    2'd2
`define MINMAX_MASK 2'd3
`endif

`ifndef PWM_OFF
`define PWM_OFF 1'b0
`define PWM_ON  1'b1
`endif

module pwm_cfg_update_ctrl #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [`PWMCOUNT_WIDTH-1:0] cfg_period,
    input  logic [`PWMCOUNT_WIDTH-1:0] cfg_init_carr,
    input  logic [1:0]                 cfg_count_mode,
    input  logic [1:0]                 cfg_mask_mode,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       maskevent,
    output logic [`PWMCOUNT_WIDTH-1:0] period,
    output logic [`PWMCOUNT_WIDTH-1:0] init_carr,
    output logic [1:0]                 count_mode,
    output logic [1:0]                 mask_mode,
    output logic                       pwm_onoff,
    output logic                       commit,
    output logic                       pending
);

    localparam logic [1:0] ST_OFF     = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PENDING = 2'd2;

    logic [1:0]                 state_q;
    logic [1:0]                 state_d;

    logic [`PWMCOUNT_WIDTH-1:0] sh_period;
    logic [`PWMCOUNT_WIDTH-1:0] sh_init_carr;
    logic [1:0]                 sh_count_mode;
    logic [1:0]                 sh_mask_mode;

    logic                       cfg_fire;
    logic                       load_cfg;
    logic                       load_shadow;
    logic                       capture_shadow;
    logic                       onoff_d;
    logic                       timeout_hit;

    assign cfg_fire = cfg_valid & cfg_ready;

`ifdef PWMCFG_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    assign timeout_hit = (tmo_cnt == (TIMEOUT_CYCLES - 16'd1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt <= '0;
        end else if (state_q != ST_PENDING) begin
            tmo_cnt <= '0;
        end else if (!(stop | maskevent | timeout_hit)) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // Only one of load_cfg / load_shadow can be set, so a commit always carries one complete field set.
    always_comb begin
        state_d        = state_q;
        load_cfg       = 1'b0;
        load_shadow    = 1'b0;
        capture_shadow = 1'b0;
        onoff_d        = pwm_onoff;
        case (state_q)
            ST_OFF: begin
                load_cfg = cfg_fire;
                if (start && !stop) begin
                    state_d = ST_RUN;
                    onoff_d = `PWM_ON;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    // Going idle: a write accepted alongside stop is applied directly.
                    load_cfg = cfg_fire;
                    state_d  = ST_OFF;
                    onoff_d  = `PWM_OFF;
                end else if (cfg_fire) begin
                    capture_shadow = 1'b1;
                    state_d        = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (stop || maskevent || timeout_hit) begin
                    load_shadow = 1'b1;
                    state_d     = stop ? ST_OFF : ST_RUN;
                    onoff_d     = stop ? `PWM_OFF : pwm_onoff;
                end
            end
            default: begin
                state_d = ST_OFF;
                onoff_d = `PWM_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_OFF;
            pwm_onoff <= `PWM_OFF;
            cfg_ready <= 1'b1;
            pending   <= 1'b0;
            commit    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pwm_onoff <= onoff_d;
            cfg_ready <= (state_d != ST_PENDING);
            pending   <= (state_d == ST_PENDING);
            commit    <= load_cfg | load_shadow;
        end
    end

    // The shadow only moves on capture, so it stays frozen for the whole PENDING stay.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sh_period     <= '0;
            sh_init_carr  <= '0;
            sh_count_mode <= '0;
            sh_mask_mode  <= '0;
        end else if (capture_shadow) begin
            sh_period     <= cfg_period;
            sh_init_carr  <= cfg_init_carr;
            sh_count_mode <= cfg_count_mode;
            sh_mask_mode  <= cfg_mask_mode;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            period     <= '0;
            init_carr  <= '0;
            count_mode <= `COUNT_UP;
            mask_mode  <= `NO_MASK;
        end else if (load_shadow) begin
            period     <= sh_period;
            init_carr  <= sh_init_carr;
            count_mode <= sh_count_mode;
            mask_mode  <= sh_mask_mode;
        end else if (load_cfg) begin
            period     <= cfg_period;
            init_carr  <= cfg_init_carr;
            count_mode <= cfg_count_mode;
            mask_mode  <= cfg_mask_mode;
        end
    end

endmodule

// File: tb/tb_pwm_cfg_update_ctrl.sv
// Scoreboard bench for pwm_cfg_update_ctrl: a rule-level model queues expected status and commits,
// and an independent monitor compares them against the DUT after every rising edge.
`timescale 1ns/1ps

`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

module tb_pwm_cfg_update_ctrl;

    localparam int W = `PWMCOUNT_WIDTH;

    localparam logic [1:0] C_COUNT_UPDOWN = 2'd2;
    localparam logic [1:0] C_MIN_MASK     = 2'd1;

    typedef struct packed {
        logic [W-1:0] period;
        logic [W-1:0] init;
        logic [1:0]   cm;
        logic [1:0]   mm;
    } cfg_t;

    typedef struct {
        bit rst;
        bit commit;
        bit pending;
        bit ready;
        bit onoff;
    } st_t;

    logic         clk;
    logic         resetn;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_period;
    logic [W-1:0] cfg_init_carr;
    logic [1:0]   cfg_count_mode;
    logic [1:0]   cfg_mask_mode;
    logic         start;
    logic         stop;
    logic         maskevent;
    logic [W-1:0] period;
    logic [W-1:0] init_carr;
    logic [1:0]   count_mode;
    logic [1:0]   mask_mode;
    logic         pwm_onoff;
    logic         commit;
    logic         pending;

    pwm_cfg_update_ctrl #(
        .TIMEOUT_CYCLES(16'd65535)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_period    (cfg_period),
        .cfg_init_carr (cfg_init_carr),
        .cfg_count_mode(cfg_count_mode),
        .cfg_mask_mode (cfg_mask_mode),
        .start         (start),
        .stop          (stop),
        .maskevent     (maskevent),
        .period        (period),
        .init_carr     (init_carr),
        .count_mode    (count_mode),
        .mask_mode     (mask_mode),
        .pwm_onoff     (pwm_onoff),
        .commit        (commit),
        .pending       (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    st_t  sq[$];
    cfg_t cq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    bit   m_running;
    bit   m_has_shadow;
    cfg_t m_shadow;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one status record per edge, and one expected field set whenever a commit is due.
    initial begin
        st_t  s;
        cfg_t last;
        last = '0;
        forever begin
            @(posedge clk);
            #2;
            if (sq.size() != 0) begin
                s = sq.pop_front();
                if (s.rst) last = '0;
                check("commit", 64'(commit), 64'(s.commit));
                check("pending", 64'(pending), 64'(s.pending));
                check("cfg_ready", 64'(cfg_ready), 64'(s.ready));
                check("pwm_onoff", 64'(pwm_onoff), 64'(s.onoff));
                if (s.commit) begin
                    if (cq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL commit_queue: got empty expected an entry at %0t", $time);
                    end else begin
                        last = cq.pop_front();
                    end
                end
                check("active_fields", 64'({period, init_carr, count_mode, mask_mode}), 64'(last));
            end
        end
    end

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c.period = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
        c.init   = W'($urandom);
        c.cm     = 2'($urandom_range(0, 2));
        c.mm     = 2'($urandom_range(0, 3));
        return c;
    endfunction

    function automatic cfg_t mk_cfg(input int p, input int i, input logic [1:0] cm, input logic [1:0] mm);
        cfg_t c;
        c.period = W'(p);
        c.init   = W'(i);
        c.cm     = cm;
        c.mm     = mm;
        return c;
    endfunction

    // One clock of stimulus; the model decides what must be visible after the coming rising edge.
    task automatic cycle(input bit v, input cfg_t c, input bit st, input bit sp, input bit me, input bit rn);
        st_t  s;
        bit   do_commit;
        cfg_t newact;
        cfg_valid = v;
        {cfg_period, cfg_init_carr, cfg_count_mode, cfg_mask_mode} = c;
        start     = st;
        stop      = sp;
        maskevent = me;
        resetn    = rn;
        s = '{default: 0};
        newact = '0;
        if (!rn) begin
            m_running    = 0;
            m_has_shadow = 0;
            m_shadow     = '0;
            s.rst        = 1;
            s.ready      = 1;
        end else begin
            do_commit = 0;
            if (m_has_shadow) begin
                if (sp || me) begin
                    newact       = m_shadow;
                    do_commit    = 1;
                    m_has_shadow = 0;
                end
            end else if (v) begin
                if (!m_running || sp) begin
                    newact    = c;
                    do_commit = 1;
                end else begin
                    m_shadow     = c;
                    m_has_shadow = 1;
                end
            end
            if (sp) m_running = 0;
            else if (st) m_running = 1;
            if (do_commit) cq.push_back(newact);
            s.commit  = do_commit;
            s.pending = m_has_shadow;
            s.ready   = !m_has_shadow;
            s.onoff   = m_running;
        end
        sq.push_back(s);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit me);
        for (int k = 0; k < n; k++) cycle(0, rand_cfg(), 0, 0, me, 1);
    endtask

    initial begin
        resetn    = 1'b0;
        cfg_valid = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        maskevent = 1'b0;
        {cfg_period, cfg_init_carr, cfg_count_mode, cfg_mask_mode} = '0;
        m_running = 0;
        m_has_shadow = 0;
        m_shadow = '0;
        @(negedge clk);
        cycle(0, rand_cfg(), 0, 0, 0, 0);
        cycle(0, rand_cfg(), 0, 0, 0, 0);
        idle(2, 0);

        // Direct load while off
        cycle(1, mk_cfg(100, 5, C_COUNT_UPDOWN, C_MIN_MASK), 0, 0, 0, 1);
        idle(3, 0);

        // Start and config on the same edge
        cycle(1, mk_cfg(10, 3, 2'd1, 2'd0), 1, 0, 0, 1);
        idle(2, 0);

        // Long wait for the update window
        cycle(1, mk_cfg(200, 7, 2'd0, 2'd2), 0, 0, 0, 1);
        idle(49, 0);
        cycle(0, rand_cfg(), 0, 0, 1, 1);
        idle(3, 0);

        // Stop while pending commits the shadow
        cycle(1, mk_cfg(300, 1, 2'd2, 2'd3), 0, 0, 0, 1);
        idle(3, 0);
        cycle(0, rand_cfg(), 0, 1, 0, 1);
        idle(2, 0);

        // Stop beats start; stop with maskevent commits once
        cycle(0, rand_cfg(), 1, 1, 0, 1);
        cycle(0, rand_cfg(), 1, 0, 0, 1);
        cycle(1, mk_cfg(0, 9, 2'd1, 2'd1), 0, 0, 0, 1);
        cycle(0, rand_cfg(), 1, 1, 1, 1);
        idle(2, 1);

        // No forced commit in the default build
        cycle(0, rand_cfg(), 1, 0, 0, 1);
        cycle(1, mk_cfg(444, 4, 2'd0, 2'd1), 0, 0, 0, 1);
        idle(1000, 0);
        cycle(0, rand_cfg(), 0, 0, 1, 1);

        // Reset during pending discards the shadow
        cycle(1, mk_cfg(555, 5, 2'd2, 2'd2), 0, 0, 0, 1);
        idle(3, 0);
        cycle(0, rand_cfg(), 0, 0, 1, 0);
        idle(3, 1);

        for (int k = 0; k < 3000; k++) begin
            cycle(bit'($urandom_range(0, 1)), rand_cfg(),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 199) != 0);
        end
        idle(4, 1);

        check("commit_queue_drained", 64'(cq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_cfg_update_ctrl.md
PWM_CFG_UPDATE_CTRL -- requirements
Module: pwm_cfg_update_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter TIMEOUT_CYCLES, default 16'd65535, is the cycles in PENDING before a forced commit (used only with the Configuration macro).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 resetn  in  1  asynchronous active-low reset.
REQ-005 cfg_valid / cfg_ready  in / out  1 / 1  configuration handshake; transfer occurs when both are 1 on a rising edge.
REQ-006 cfg_period, cfg_init_carr  in  `PWMCOUNT_WIDTH each  requested period and initial carrier value.
REQ-007 cfg_count_mode, cfg_mask_mode  in  _count_mode, _mask_mode  requested counting and mask modes.
REQ-008 start, stop  in  1 each  single-cycle run and halt requests.
REQ-009 maskevent  in  1  update-window flag from the carrier generator.
REQ-010 period, init_carr  out  `PWMCOUNT_WIDTH each  active values driven to the carrier generator.
REQ-011 count_mode, mask_mode, pwm_onoff  out  _count_mode, _mask_mode, _pwm_onoff  active settings.
REQ-012 commit  out  1  single-cycle pulse on every update of the active settings.
REQ-013 pending  out  1  shadow holds an uncommitted configuration.

Function
REQ-014 The FSM SHALL have states OFF, RUN and PENDING; all outputs are registered.
REQ-015 OFF: pwm_onoff=PWM_OFF, cfg_ready=1; an accepted cfg SHALL load the active outputs on the same edge, and commit=1 on the next cycle.
REQ-016 OFF with start=1: next state RUN, and pwm_onoff=PWM_ON from the next cycle.
REQ-017 OFF with start=1 and an accepted cfg on the same edge: both SHALL take effect on that edge.
REQ-018 RUN: cfg_ready=1; an accepted cfg SHALL load the shadow registers, set pending=1 and move the FSM to PENDING.
REQ-019 PENDING: cfg_ready=0 and the shadow is frozen.
REQ-020 PENDING with maskevent=1: on that edge the shadow SHALL be copied to the active outputs, commit pulses 1 cycle, pending clears and the FSM returns to RUN.
REQ-021 Commit latency: active outputs change 1 edge after the first maskevent=1 sample in PENDING; with mask_mode=NO_MASK this is 1 cycle after entering PENDING.
REQ-022 stop=1 in any state SHALL move the FSM to OFF with pwm_onoff=PWM_OFF from the next cycle.
REQ-023 stop=1 in PENDING SHALL commit the shadow on the same edge (commit pulses), so no write is lost.
REQ-024 stop and start both 1: stop wins.
REQ-025 stop and maskevent both 1 in PENDING: exactly one commit, and the FSM goes to OFF.
REQ-026 start in RUN or PENDING SHALL be ignored; stop in OFF SHALL be ignored apart from REQ-015 cfg handling.
REQ-027 cfg_period=0 SHALL be accepted and committed unmodified; the carrier generator holds its carrier at 0.
REQ-028 Active outputs SHALL change only via commit, and only one field set is committed atomically (no partial updates).

Reset
REQ-029 On resetn=0: state=OFF, period=0, init_carr=0, count_mode=COUNT_UP, mask_mode=NO_MASK, pwm_onoff=PWM_OFF, cfg_ready=1 (after release), commit=0, pending=0, shadow=0, timeout counter=0.
REQ-030 Reset asserted mid-PENDING SHALL discard the shadow without a commit.

Configuration
REQ-031 Macro PWMCFG_TIMEOUT_EN defined: a 16-bit counter clears on PENDING entry and increments each PENDING cycle. When it reaches TIMEOUT_CYCLES-1 without maskevent, the block SHALL force the commit exactly as in REQ-020.
REQ-032 Macro PWMCFG_TIMEOUT_EN undefined: no counter exists, and PENDING exits only via maskevent, stop or reset.

Verification
REQ-033 OFF, cfg period=100, init=5, COUNT_UPDOWN, MIN_MASK -> outputs equal those values next cycle, commit=1 for 1 cycle, pwm_onoff stays OFF.
REQ-034 RUN, cfg period=200, maskevent held 0 for 50 cycles then 1 -> pending=1 and cfg_ready=0 for 50 cycles; period=200 one edge after maskevent; one commit pulse.
REQ-035 PENDING, stop=1 with maskevent=0 -> shadow committed, pwm_onoff=PWM_OFF next cycle, FSM OFF.
REQ-036 OFF, start=1 with cfg_valid=1 (period=10) in the same cycle -> period=10 and pwm_onoff=PWM_ON on the same cycle.
REQ-037 Macro defined, TIMEOUT_CYCLES=8, RUN, cfg accepted, maskevent=0 -> commit 8 cycles after PENDING entry; macro undefined -> no commit after 1000 cycles.
REQ-038 resetn asserted 3 cycles into PENDING -> all outputs at their REQ-029 values, no commit pulse.
